// File: rtl/hevc_ref_block_fetch_pkg.sv
// Shared constants, FSM state type and helpers for the fractional-sample
// reference fetch path.
package hevc_sr_pkg;

  localparam int TAP      = 8;
  localparam int HALF_TAP = TAP / 2 - 1;
  localparam int ALPHA_W  = 3;
  localparam int EXT_W    = 7;
  localparam int PEL_W    = 8;

  typedef enum logic [1:0] {IDLE, CFG, FETCH, DRAIN} sr_state_e;

  // Only square prediction blocks of 4..64 are meaningful to the filter.
  function automatic logic size_legal(input logic [6:0] size);
    case (size)
      7'd4, 7'd8, 7'd16, 7'd32, 7'd64: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  // Picture-edge replication: pull a coordinate into 0..max.
  function automatic int clamp(input int v, input int max);
    if (v < 0)   return 0;
    if (v > max) return max;
    return v;
  endfunction

endpackage

// File: rtl/hevc_ref_block_fetch_if.sv
// Command, reference-RAM and filter-token signals of the block fetcher.
// master = the fetcher, slave = its environment (command source, RAM, filter).
interface hevc_ref_block_fetch_if #(
  parameter int COORD_W = 13,
  parameter int ADDR_W  = 11
);
  import hevc_sr_pkg::*;

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic signed [COORD_W-1:0]  cmd_x;
  logic signed [COORD_W-1:0]  cmd_y;
  logic [1:0]                 cmd_frac_x;
  logic [1:0]                 cmd_frac_y;
  logic [6:0]                 cmd_size;

  logic                       mem_rd;
  logic [ADDR_W-1:0]          mem_addr;
  logic [PEL_W-1:0]           mem_rdata;

  logic [ALPHA_W-1:0]         v_alpha_din;
  logic                       v_alpha_write;
  logic                       v_alpha_full;
  logic [ALPHA_W-1:0]         h_alpha_din;
  logic                       h_alpha_write;
  logic                       h_alpha_full;
  logic [EXT_W-1:0]           ext_size_din;
  logic                       ext_size_write;
  logic                       ext_size_full;
  logic [PEL_W-1:0]           pel_din;
  logic                       pel_write;
  logic                       pel_full;

  logic                       err;

  modport master (
    input  cmd_valid, cmd_x, cmd_y, cmd_frac_x, cmd_frac_y, cmd_size,
    output cmd_ready,
    output mem_rd, mem_addr,
    input  mem_rdata,
    output v_alpha_din, v_alpha_write,
    input  v_alpha_full,
    output h_alpha_din, h_alpha_write,
    input  h_alpha_full,
    output ext_size_din, ext_size_write,
    input  ext_size_full,
    output pel_din, pel_write,
    input  pel_full,
    output err
  );

  modport slave (
    output cmd_valid, cmd_x, cmd_y, cmd_frac_x, cmd_frac_y, cmd_size,
    input  cmd_ready,
    input  mem_rd, mem_addr,
    output mem_rdata,
    input  v_alpha_din, v_alpha_write,
    output v_alpha_full,
    input  h_alpha_din, h_alpha_write,
    output h_alpha_full,
    input  ext_size_din, ext_size_write,
    output ext_size_full,
    input  pel_din, pel_write,
    output pel_full,
    input  err
  );

endinterface

// File: rtl/hevc_ref_block_fetch_fifo2.sv
// Two-entry pixel FIFO between the RAM read port and the pel stream.
// Push and pop may coincide at any non-zero occupancy.
module sr_pel_fifo2
  import hevc_sr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [PEL_W-1:0] din,
  input  logic             pop,
  output logic [PEL_W-1:0] dout,
  output logic [1:0]       count
);

  logic [PEL_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage; contents are qualified by count so they need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/hevc_ref_block_fetch.sv
// Reference block fetcher: takes one MC command, sends the filter its
// phase/size tokens, then streams the clamped (size+7)^2 window in raster order.
module hevc_ref_block_fetch
  import hevc_sr_pkg::*;
#(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 32,
  parameter int ADDR_W  = $clog2(FRAME_W * FRAME_H),
  parameter int COORD_W = 13
)(
  input  logic                  clk,
  input  logic                  rst,
  hevc_ref_block_fetch_if.master bus
);

  sr_state_e                 state;
  logic                      cmd_ready_q;
  logic                      err_q;
  logic signed [COORD_W-1:0] x_q;
  logic signed [COORD_W-1:0] y_q;
  logic [1:0]                fx_q;
  logic [1:0]                fy_q;
  logic [6:0]                size_q;
  logic                      v_sent, h_sent, e_sent;
  logic [6:0]                row, col;
  logic [6:0]                ext_last;
  logic                      accept;
  logic                      v_wr, h_wr, e_wr;
  logic                      rd_p0;
  logic                      vld_p1;
  logic                      pel_pop;
  logic [1:0]                fifo_cnt;
  logic [PEL_W-1:0]          fifo_head;
  logic [2:0]                occ;
  logic signed [COORD_W:0]   sx, sy;
  int                        xs, ys;
  logic [ADDR_W-1:0]         rd_addr;

  assign accept   = bus.cmd_valid & cmd_ready_q;
  assign ext_last = size_q + 7'(TAP - 2);

  // Token writes are gated by the consumer's full in the same cycle.
  assign v_wr = (state == CFG) && !v_sent && !bus.v_alpha_full;
  assign h_wr = (state == CFG) && !h_sent && !bus.h_alpha_full;
  assign e_wr = (state == CFG) && !e_sent && !bus.ext_size_full;

  assign bus.v_alpha_write  = v_wr;
  assign bus.h_alpha_write  = h_wr;
  assign bus.ext_size_write = e_wr;
  assign bus.v_alpha_din    = v_wr ? {fy_q, 1'b0} : '0;
  assign bus.h_alpha_din    = h_wr ? {fx_q, 1'b0} : '0;
  assign bus.ext_size_din   = e_wr ? EXT_W'(size_q + 7'(TAP - 1)) : '0;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.err       = err_q;

  // Window position with edge clamping; col/row offsets are non-negative.
  always_comb begin
    sx      = {x_q[COORD_W-1], x_q} - (COORD_W+1)'(HALF_TAP) + (COORD_W+1)'(col);
    sy      = {y_q[COORD_W-1], y_q} - (COORD_W+1)'(HALF_TAP) + (COORD_W+1)'(row);
    xs      = clamp(int'(sx), FRAME_W - 1);
    ys      = clamp(int'(sy), FRAME_H - 1);
    rd_addr = ADDR_W'(ys * FRAME_W + xs);
  end

  // Credit check counts the pop happening this cycle so a free-running
  // consumer sees one pel per cycle while the FIFO can never exceed two.
  assign pel_pop = (fifo_cnt != 2'd0) && !bus.pel_full;
  assign occ     = {1'b0, fifo_cnt} + {2'b0, vld_p1} - {2'b0, pel_pop};
  assign rd_p0   = (state == FETCH) && (occ < 3'd2);

  assign bus.mem_rd   = rd_p0;
  assign bus.mem_addr = rd_p0 ? rd_addr : '0;

  // Command fields are held for the life of the block.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q    <= bus.cmd_x;
      y_q    <= bus.cmd_y;
      fx_q   <= bus.cmd_frac_x;
      fy_q   <= bus.cmd_frac_y;
      size_q <= bus.cmd_size;
    end
  end

  // Control FSM: command accept, token issue, window scan, drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      err_q       <= 1'b0;
      v_sent      <= 1'b0;
      h_sent      <= 1'b0;
      e_sent      <= 1'b0;
      row         <= '0;
      col         <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (size_legal(bus.cmd_size)) begin
              state       <= CFG;
              cmd_ready_q <= 1'b0;
              v_sent      <= 1'b0;
              h_sent      <= 1'b0;
              e_sent      <= 1'b0;
              row         <= '0;
              col         <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        CFG: begin
          if (v_wr) v_sent <= 1'b1;
          if (h_wr) h_sent <= 1'b1;
          if (e_wr) e_sent <= 1'b1;
          if (v_sent && h_sent && e_sent) state <= FETCH;
        end
        FETCH: begin
          if (rd_p0) begin
            if (col == ext_last) begin
              col <= '0;
              if (row == ext_last) state <= DRAIN;
              else                 row   <= row + 7'd1;
            end else begin
              col <= col + 7'd1;
            end
          end
        end
        DRAIN: begin
          if (!vld_p1 && fifo_cnt == 2'd0) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: RAM data returns one cycle after the read strobe ----
  always_ff @(posedge clk) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= rd_p0;
  end

  sr_pel_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .din   (bus.mem_rdata),
    .pop   (pel_pop),
    .dout  (fifo_head),
    .count (fifo_cnt)
  );

  // ---- stage p2: FIFO head to the pel stream ----
  assign bus.pel_write = pel_pop;
  assign bus.pel_din   = pel_pop ? fifo_head : '0;

endmodule

// File: tb/tb_hevc_ref_block_fetch.sv
// Directed bench for hevc_ref_block_fetch with a pel(x,y)=(x+2y)&255 RAM.
module tb_hevc_ref_block_fetch;

  localparam int FW = 64;
  localparam int FH = 32;
  localparam int AW = 11;
  localparam int CW = 13;

  logic clk = 1'b0;
  logic rst;

  hevc_ref_block_fetch_if #(.COORD_W(CW), .ADDR_W(AW)) bus ();

  hevc_ref_block_fetch #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .ADDR_W  (AW),
    .COORD_W (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int pel(input int x, input int y);
    return (x + 2 * y) & 255;
  endfunction

  function automatic int clampi(input int v, input int mx);
    return (v < 0) ? 0 : ((v > mx) ? mx : v);
  endfunction

  function automatic int exp_pel(input int x0, input int y0, input int ext, input int idx);
    int r, c;
    r = idx / ext;
    c = idx % ext;
    return pel(clampi(x0 - 3 + c, FW - 1), clampi(y0 - 3 + r, FH - 1));
  endfunction

  // Reference RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= 8'(pel(int'(bus.mem_addr) % FW, int'(bus.mem_addr) / FW));
  end

  // Output monitor, sampled mid-cycle.
  int got[$];
  int n_tok = 0, n_err = 0, n_rd = 0, ord_viol = 0, full_viol = 0, tok_since = 0;
  int v_tok = -1, h_tok = -1, e_tok = -1;

  always @(negedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) tok_since = 0;
    if (bus.v_alpha_write)  begin v_tok = int'(bus.v_alpha_din);  n_tok++; tok_since++; end
    if (bus.h_alpha_write)  begin h_tok = int'(bus.h_alpha_din);  n_tok++; tok_since++; end
    if (bus.ext_size_write) begin e_tok = int'(bus.ext_size_din); n_tok++; tok_since++; end
    if (bus.ext_size_write && bus.ext_size_full) full_viol++;
    if (bus.pel_write) begin
      got.push_back(int'(bus.pel_din));
      if (tok_since < 3) ord_viol++;
      if (bus.pel_full)  full_viol++;
    end
    if (bus.mem_rd) n_rd++;
    if (bus.err)    n_err++;
  end

  // Back-pressure driver: pel_full 1,1,0 pattern and random ext_size_full.
  logic stress = 1'b0;
  initial begin
    int ph;
    ph = 0;
    bus.pel_full      = 1'b0;
    bus.ext_size_full = 1'b0;
    bus.v_alpha_full  = 1'b0;
    bus.h_alpha_full  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stress) begin
        bus.pel_full      = (ph != 2);
        ph                = (ph == 2) ? 0 : ph + 1;
        bus.ext_size_full = 1'($urandom_range(0, 1));
      end else begin
        ph                = 0;
        bus.pel_full      = 1'b0;
        bus.ext_size_full = 1'b0;
      end
    end
  end

  function automatic int g(input int i);
    return (i < got.size()) ? got[i] : -1;
  endfunction

  task automatic send_cmd(input int x, input int y, input int size, input int fx, input int fy);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) check("cmd_ready_wait", 0, 1);
    bus.cmd_x      = CW'(x);
    bus.cmd_y      = CW'(y);
    bus.cmd_size   = 7'(size);
    bus.cmd_frac_x = 2'(fx);
    bus.cmd_frac_y = 2'(fy);
    bus.cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic wait_pels(input string tag, input int base, input int n);
    int cyc;
    cyc = 0;
    while ((got.size() - base < n || !bus.cmd_ready) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 5000) check({tag, "_timeout"}, 0, 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_stream(input string tag, input int base, input int x0, input int y0, input int ext);
    int mism;
    mism = 0;
    for (int i = 0; i < ext * ext; i++)
      if (g(base + i) != exp_pel(x0, y0, ext, i)) mism++;
    check(tag, mism, 0);
  endtask

  int s1[$];

  initial begin
    int b, t0, r0, e0, ov0, fv0, mism;
    rst            = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_x      = '0;
    bus.cmd_y      = '0;
    bus.cmd_size   = '0;
    bus.cmd_frac_x = '0;
    bus.cmd_frac_y = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(bus.cmd_ready), 0);
    check("rst_mem_rd",    int'(bus.mem_rd), 0);
    check("rst_outputs",   int'({bus.pel_write, bus.v_alpha_write, bus.h_alpha_write,
                                 bus.ext_size_write, bus.err, bus.mem_addr}), 0);
    rst = 1'b1;

    // Scenario 1: interior block
    b = got.size(); t0 = n_tok; r0 = n_rd;
    send_cmd(16, 8, 4, 1, 1);
    wait_pels("s1", b, 121);
    check("s1_tok_cnt", n_tok - t0, 3);
    check("s1_v_alpha", v_tok, 2);
    check("s1_h_alpha", h_tok, 2);
    check("s1_ext_size", e_tok, 11);
    check("s1_count", got.size() - b, 121);
    check("s1_reads", n_rd - r0, 121);
    check("s1_first", g(b), 23);
    check("s1_last", g(b + 120), 53);
    check_stream("s1_stream", b, 16, 8, 11);
    for (int i = 0; i < 121; i++) s1.push_back(g(b + i));

    // Scenario 2: top-left corner clamping
    b = got.size();
    send_cmd(0, 0, 8, 0, 0);
    wait_pels("s2", b, 225);
    check("s2_v_alpha", v_tok, 0);
    check("s2_h_alpha", h_tok, 0);
    check("s2_ext_size", e_tok, 15);
    check("s2_count", got.size() - b, 225);
    check("s2_c0", g(b), 0);
    check("s2_c3", g(b + 3), 0);
    check("s2_c4", g(b + 4), 1);
    mism = 0;
    for (int r = 1; r < 4; r++)
      for (int c = 0; c < 15; c++)
        if (g(b + r * 15 + c) != g(b + c)) mism++;
    check("s2_rows0_3_equal", mism, 0);
    check("s2_row4_start", g(b + 60), 2);
    check("s2_last", g(b + 224), 33);
    check_stream("s2_stream", b, 0, 0, 15);

    // Scenario 3: bottom-right corner clamping
    b = got.size();
    send_cmd(60, 28, 4, 2, 3);
    wait_pels("s3", b, 121);
    check("s3_v_alpha", v_tok, 6);
    check("s3_h_alpha", h_tok, 4);
    check("s3_count", got.size() - b, 121);
    check("s3_first", g(b), 107);
    check("s3_c6", g(b + 6), 113);
    check("s3_c10", g(b + 10), 113);
    check("s3_r6", g(b + 66), 119);
    check("s3_r10", g(b + 110), 119);
    check("s3_last", g(b + 120), 125);
    check_stream("s3_stream", b, 60, 28, 11);

    // Scenario 4: scenario 1 under back-pressure
    b = got.size(); fv0 = full_viol;
    stress = 1'b1;
    send_cmd(16, 8, 4, 1, 1);
    wait_pels("s4", b, 121);
    stress = 1'b0;
    check("s4_ext_size", e_tok, 11);
    check("s4_count", got.size() - b, 121);
    mism = 0;
    for (int i = 0; i < 121; i++)
      if (g(b + i) != s1[i]) mism++;
    check("s4_same_as_s1", mism, 0);
    check("s4_write_while_full", full_viol - fv0, 0);

    // Scenario 5: illegal size, then a legal command straight after
    b = got.size(); t0 = n_tok; r0 = n_rd; e0 = n_err;
    send_cmd(16, 8, 12, 1, 1);
    send_cmd(16, 8, 4, 1, 1);
    wait_pels("s5", b, 121);
    check("s5_err_pulses", n_err - e0, 1);
    check("s5_tok_cnt", n_tok - t0, 3);
    check("s5_reads", n_rd - r0, 121);
    check("s5_count", got.size() - b, 121);
    check("s5_first", g(b), 23);

    // Scenario 6: reset after the 50th pel, then a clean rerun
    b = got.size();
    send_cmd(16, 8, 4, 1, 1);
    t0 = 0;
    while (got.size() - b < 50 && t0 < 2000) begin
      @(negedge clk);
      t0++;
    end
    check("s6_reached_50", (got.size() - b >= 50) ? 1 : 0, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("s6_rst_cmd_ready", int'(bus.cmd_ready), 0);
    check("s6_rst_mem", int'({bus.mem_rd, bus.mem_addr}), 0);
    check("s6_rst_writes", int'({bus.pel_write, bus.v_alpha_write, bus.h_alpha_write,
                                 bus.ext_size_write, bus.err}), 0);
    check("s6_rst_dins", int'({bus.pel_din, bus.v_alpha_din, bus.h_alpha_din,
                               bus.ext_size_din}), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    b = got.size(); ov0 = ord_viol;
    send_cmd(16, 8, 4, 1, 1);
    wait_pels("s6", b, 121);
    check("s6_count", got.size() - b, 121);
    check("s6_first", g(b), 23);
    check_stream("s6_stream", b, 16, 8, 11);
    check("s6_order", ord_viol - ov0, 0);
    check("all_order", ord_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
